// File: rtl/noc_port_arbiter.sv
// Packet-level round-robin arbiter: several input FIFOs share one output port.
// A port that starts a packet keeps the output until its tail flit transfers.
module noc_port_arbiter #(
    parameter int NUM_IN = 5,
    parameter int WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_tail,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_tail,
    input  logic                    out_ready,
    output logic [NUM_IN-1:0]       grant,
    output logic                    locked,
    output logic [15:0]             pkt_count
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_IN);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   idx_sum;
    logic             any_valid;
    logic             transfer;
    logic             tail_xfer;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign locked    = (state == LOCKED);
    assign any_valid = |in_valid;

    // Scan downward so the last hit is the first valid port at or after rr_ptr.
    always_comb begin
        cand    = '0;
        idx_sum = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx_sum >= NUM_EXT) begin
                idx_sum = idx_sum - NUM_EXT;
            end
            if (in_valid[idx_sum[IDX_W-1:0]]) begin
                cand = idx_sum[IDX_W-1:0];
            end
        end
    end

    // A locked owner keeps its grant even through a bubble in its packet.
    always_comb begin
        sel      = locked ? owner : cand;
        grant    = '0;
        out_data = '0;
        out_tail = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == IDX_W'(i)) begin
                grant[i] = locked || any_valid;
                out_data = in_data[i*WIDTH +: WIDTH];
                out_tail = in_tail[i];
            end
        end
    end

    assign out_valid = |(grant & in_valid);
    assign in_ready  = {NUM_IN{out_ready}} & grant;
    assign transfer  = out_valid && out_ready;
    assign tail_xfer = transfer && out_tail;

    // Locking on a stalled head flit keeps out_data stable until it is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            if (tail_xfer) begin
                pkt_count <= pkt_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        if (tail_xfer) begin
                            rr_ptr <= next_ptr(cand);
                        end else begin
                            state <= LOCKED;
                            owner <= cand;
                        end
                    end
                end
                default: begin
                    if (tail_xfer) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(owner);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed scoreboard bench for noc_port_arbiter (NUM_IN=5, WIDTH=64):
// each vector pushes its expected outputs; a negedge monitor pops and compares.
module tb_noc_port_arbiter;

    localparam int NUM_IN = 5;
    localparam int WIDTH  = 64;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_tail;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_tail;
    logic                    out_ready;
    logic [NUM_IN-1:0]       grant;
    logic                    locked;
    logic [15:0]             pkt_count;

    typedef struct {
        int          id;
        logic [4:0]  grant;
        logic        locked;
        logic        valid;
        logic        tail;
        logic [63:0] data;
        logic [4:0]  rdy;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks;
    int   passed_checks;
    int   vec_id;

    noc_port_arbiter #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_tail  (out_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .locked    (locked),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each port carries a flit tagged with its port number and the vector id.
    function automatic logic [63:0] data_of(input int p, input int id);
        return {8'hA0 + 8'(p), 24'h0, 32'(id)};
    endfunction

    task automatic checkOutput(input string name, input int id,
                               input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s vec%0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [4:0] v, input logic [4:0] t,
                                 input logic rdy, input logic [4:0] eg, input logic el,
                                 input logic ev, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        in_valid  = v;
        in_tail   = t;
        out_ready = rdy;
        for (int p = 0; p < NUM_IN; p++) begin
            in_data[p*WIDTH +: WIDTH] = data_of(p, vec_id);
        end
        e.id     = vec_id;
        e.grant  = eg;
        e.locked = el;
        e.valid  = ev;
        e.tail   = |(eg & t);
        e.data   = '0;
        for (int p = 0; p < NUM_IN; p++) begin
            if (eg[p]) e.data = data_of(p, vec_id);
        end
        e.rdy    = rdy ? eg : 5'b0;
        e.cnt    = ec;
        exp_q.push_back(e);
        vec_id++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("grant",     e.id, 64'(grant),     64'(e.grant));
            checkOutput("locked",    e.id, 64'(locked),    64'(e.locked));
            checkOutput("out_valid", e.id, 64'(out_valid), 64'(e.valid));
            checkOutput("in_ready",  e.id, 64'(in_ready),  64'(e.rdy));
            checkOutput("pkt_count", e.id, 64'(pkt_count), 64'(e.cnt));
            if (e.valid) begin
                checkOutput("out_data", e.id, out_data,       e.data);
                checkOutput("out_tail", e.id, 64'(out_tail), 64'(e.tail));
            end
        end
    end

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        vec_id        = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_tail   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset, then ports 1 and 3 each send one single-flit packet.
        applyStimulus(0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 16'd0);
        applyStimulus(0, 5'b01010, 5'b01010, 1, 5'b00010, 0, 1, 16'd0);
        applyStimulus(1, 5'b01010, 5'b01010, 1, 5'b00010, 0, 1, 16'd0);
        applyStimulus(1, 5'b01000, 5'b01000, 1, 5'b01000, 0, 1, 16'd1);

        // Port 4 wins from rr_ptr=4, stalls on its head flit, then port 0 appears.
        applyStimulus(1, 5'b10000, 5'b00000, 0, 5'b10000, 0, 1, 16'd2);
        applyStimulus(1, 5'b10000, 5'b00000, 0, 5'b10000, 1, 1, 16'd2);
        applyStimulus(1, 5'b10000, 5'b00000, 0, 5'b10000, 1, 1, 16'd2);
        applyStimulus(1, 5'b10001, 5'b00001, 0, 5'b10000, 1, 1, 16'd2);
        applyStimulus(1, 5'b10001, 5'b00001, 1, 5'b10000, 1, 1, 16'd2);
        applyStimulus(1, 5'b10001, 5'b10001, 1, 5'b10000, 1, 1, 16'd2);
        applyStimulus(1, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 16'd3);

        // Fresh reset, then port 0 sends 3 flits while port 2 waits.
        applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 16'd4);
        applyStimulus(1, 5'b00101, 5'b00000, 1, 5'b00001, 0, 1, 16'd0);
        applyStimulus(1, 5'b00101, 5'b00000, 1, 5'b00001, 1, 1, 16'd0);
        applyStimulus(1, 5'b00101, 5'b00001, 1, 5'b00001, 1, 1, 16'd0);
        applyStimulus(1, 5'b00100, 5'b00100, 1, 5'b00100, 0, 1, 16'd1);

        // Owner 3 bubbles for 2 cycles while port 1 waits.
        applyStimulus(1, 5'b01000, 5'b00000, 1, 5'b01000, 0, 1, 16'd2);
        applyStimulus(1, 5'b00010, 5'b00010, 1, 5'b01000, 1, 0, 16'd2);
        applyStimulus(1, 5'b00010, 5'b00010, 1, 5'b01000, 1, 0, 16'd2);
        applyStimulus(1, 5'b01010, 5'b01010, 1, 5'b01000, 1, 1, 16'd2);
        applyStimulus(1, 5'b00010, 5'b00010, 1, 5'b00010, 0, 1, 16'd3);

        // Reset pulsed while locked on port 2.
        applyStimulus(1, 5'b00101, 5'b00000, 1, 5'b00100, 0, 1, 16'd4);
        applyStimulus(1, 5'b00101, 5'b00000, 1, 5'b00100, 1, 1, 16'd4);
        applyStimulus(0, 5'b00101, 5'b00000, 0, 5'b00100, 1, 1, 16'd4);
        applyStimulus(1, 5'b00101, 5'b00001, 1, 5'b00001, 0, 1, 16'd0);
        applyStimulus(1, 5'b00100, 5'b00100, 1, 5'b00100, 0, 1, 16'd1);

        // Stream single-flit packets from port 0 until the counter sits at 0xFFFF.
        @(posedge clk);
        #1;
        in_valid  = 5'b00001;
        in_tail   = 5'b00001;
        out_ready = 1'b1;
        repeat (65532) @(posedge clk);

        applyStimulus(1, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 16'hFFFF);
        applyStimulus(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 16'h0000);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total_checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
